// File: rtl/cpu_pkg.sv
// Shared types and constants for the MIPS pipeline: bubble encoding, reset PC
// and the IF/ID pipeline-register payload.
package cpu_pkg;

   localparam logic [31:0] NOP_WORD         = 32'h0000_0000;  // sll $0,$0,0
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc_plus4;
      logic        valid;
   } if_id_t;

   // j-type target: region bits of the delay-slot PC plus the word index.
   function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                               input logic [25:0] index);
      return {region, index, 2'b00};
   endfunction

   function automatic if_id_t make_bubble(input logic [31:0] nop);
      if_id_t b;
      b.inst     = nop;
      b.pc_plus4 = 32'h0000_0000;
      b.valid    = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/ctrl_bus_if.sv
// Clock and synchronous active-high reset distributed to pipeline stages.
interface ctrl_bus_if (
   input logic clk,
   input logic reset
);

   modport central (input clk, input reset);

endinterface

// File: rtl/mem_bus_if.sv
// Combinational-read memory port: address out, data back in the same cycle.
interface mem_bus_if;

   logic [31:0] addr;
   logic [31:0] data;

   modport central (output addr, input data);
   modport memory  (input addr, output data);

endinterface

// File: rtl/ff.sv
// Generic register with clock enable and synchronous active-high reset.
module ff #(
   parameter int                 WIDTH     = 32,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // NOTE: sequential state is always written with <=, so every register
   // samples the pre-edge value of its neighbours regardless of block order.
   always_ff @(posedge clk) begin
      if (reset)
         q <= RESET_VAL;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: synchronous clear to a bubble beats enable.
module if_id_reg
   import cpu_pkg::*;
#(
   parameter logic [31:0] NOP = NOP_WORD
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   en,
   input  logic   clear,
   input  if_id_t d,
   output if_id_t q
);

   // A redirect squashes the slot even while the hazard unit is stalling.
   always_ff @(posedge clk) begin
      if (reset || clear)
         q <= make_bubble(NOP);
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/mux2.sv
// Two-input word multiplexer; sel=1 picks b.
module mux2 #(
   parameter int WIDTH = 32
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   assign y = sel ? b : a;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, redirect selection (branch from EX,
// jump decoded from IF/ID), IF/ID latch and fetch/flush event counters.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP      = NOP_WORD
) (
   ctrl_bus_if.central  ctrl_bus,
   mem_bus_if.central   imem_bus,
   input  logic         stall,
   input  logic         jmp,
   input  logic         br_taken,
   input  logic [31:0]  br_target,
   output logic [31:0]  pc,
   output logic [31:0]  id_inst,
   output logic [31:0]  id_pc_plus4,
   output logic         id_valid,
   output logic [31:0]  fetch_cnt,
   output logic [31:0]  flush_cnt
);

   logic        clk;
   logic        reset;
   logic [31:0] pc_plus4;
   logic [31:0] jmp_target;
   logic [31:0] redirect_target;
   logic [31:0] pc_next;
   logic        jmp_take;
   logic        redirect;
   logic        pc_en;
   logic        advance;
   if_id_t      id_d;
   if_id_t      id_q;

   assign clk   = ctrl_bus.clk;
   assign reset = ctrl_bus.reset;

   assign imem_bus.addr = pc;
   assign pc_plus4      = pc + 32'd4;
   assign jmp_target    = jump_target(id_q.pc_plus4[31:28], id_q.inst[25:0]);

   // A jump from an empty IF/ID slot is a protocol error and is ignored;
   // a stalled jump waits, but a taken branch overrides everything.
   assign jmp_take = jmp && id_q.valid && !stall;
   assign redirect = br_taken || jmp_take;
   assign pc_en    = br_taken || !stall;
   assign advance  = !redirect && !stall;

   mux2 #(.WIDTH(32)) u_target_mux (
      .sel (br_taken),
      .a   (jmp_target),
      .b   (br_target),
      .y   (redirect_target)
   );

   mux2 #(.WIDTH(32)) u_pc_mux (
      .sel (redirect),
      .a   (pc_plus4),
      .b   (redirect_target),
      .y   (pc_next)
   );

   ff #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc_reg (
      .clk   (clk),
      .reset (reset),
      .en    (pc_en),
      .d     (pc_next),
      .q     (pc)
   );

   // NOTE: every field is assigned unconditionally, so no latch is inferred.
   always_comb begin
      id_d.inst     = imem_bus.data;
      id_d.pc_plus4 = pc_plus4;
      id_d.valid    = 1'b1;
   end

   if_id_reg #(.NOP(NOP)) u_if_id (
      .clk   (clk),
      .reset (reset),
      .en    (!stall),
      .clear (redirect),
      .d     (id_d),
      .q     (id_q)
   );

   assign id_inst     = id_q.inst;
   assign id_pc_plus4 = id_q.pc_plus4;
   assign id_valid    = id_q.valid;

   // Free-running event counters; both wrap modulo 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt <= 32'd0;
         flush_cnt <= 32'd0;
      end else begin
         if (advance)
            fetch_cnt <= fetch_cnt + 32'd1;
         if (br_taken && id_q.valid)
            flush_cnt <= flush_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random traffic,
// scored against a behavioural model through an expected-value queue.
module tb_fetch_stage;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        jmp = 1'b0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = 32'h0;
   logic [31:0] pc, id_inst, id_pc_plus4, fetch_cnt, flush_cnt;
   logic        id_valid;

   always #5 clk = ~clk;

   ctrl_bus_if ctrl (.clk(clk), .reset(reset));
   mem_bus_if  imem ();

   fetch_stage dut (
      .ctrl_bus    (ctrl),
      .imem_bus    (imem),
      .stall       (stall),
      .jmp         (jmp),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .pc          (pc),
      .id_inst     (id_inst),
      .id_pc_plus4 (id_pc_plus4),
      .id_valid    (id_valid),
      .fetch_cnt   (fetch_cnt),
      .flush_cnt   (flush_cnt)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] pp4;
      logic        valid;
      logic [31:0] fetch;
      logic [31:0] flush;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Instruction memory: explicit words, else a fixed scramble of the address.
   logic [31:0] mem [logic [31:0]];
   int          mem_gen = 0;

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if ($isunknown(a)) return 32'h0;
      if (mem.exists(a)) return mem[a];
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   always @(imem.addr or mem_gen) imem.data = mem_read(imem.addr);

   // Reference model state
   logic [31:0] m_pc, m_inst, m_pp4, m_fetch, m_flush;
   logic        m_valid;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit s, input bit j, input bit b,
                             input logic [31:0] t);
      if (r) begin
         m_pc = RESET_PC_DEFAULT; m_inst = NOP_WORD; m_pp4 = 0; m_valid = 0;
         m_fetch = 0; m_flush = 0;
      end else if (b) begin
         if (m_valid) m_flush = m_flush + 1;
         m_pc = t; m_inst = NOP_WORD; m_pp4 = 0; m_valid = 0;
      end else if (j && m_valid && !s) begin
         m_pc = {m_pp4[31:28], m_inst[25:0], 2'b00};
         m_inst = NOP_WORD; m_pp4 = 0; m_valid = 0;
      end else if (!s) begin
         m_inst  = mem_read(m_pc);
         m_pp4   = m_pc + 32'd4;
         m_valid = 1'b1;
         m_pc    = m_pp4;
         m_fetch = m_fetch + 1;
      end
   endtask

   // Drive one cycle of inputs and queue the state expected after its edge.
   task automatic cycle(input bit r, input bit s, input bit j, input bit b,
                        input logic [31:0] t);
      @(negedge clk);
      reset = r; stall = s; jmp = j; br_taken = b; br_target = t;
      model_step(r, s, j, b, t);
      sb.push_back('{pc: m_pc, inst: m_inst, pp4: m_pp4, valid: m_valid,
                     fetch: m_fetch, flush: m_flush});
   endtask

   task automatic normal(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 32'h0);
   endtask

   task automatic after_edge;
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare DUT state one step after every edge that has an entry.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pc",          pc,          e.pc);
            check("id_inst",     id_inst,     e.inst);
            check("id_pc_plus4", id_pc_plus4, e.pp4);
            check("id_valid",    {31'h0, id_valid}, {31'h0, e.valid});
            check("fetch_cnt",   fetch_cnt,   e.fetch);
            check("flush_cnt",   flush_cnt,   e.flush);
         end
      end
   end

   initial begin
      int guard;
      bit r, s, j, b;
      logic [31:0] t;

      mem[32'h0] = 32'h2008_0005;
      mem[32'h4] = 32'h2009_0003;
      mem[32'h8] = 32'h0109_5020;
      mem_gen++;

      // Reset and three free-running fetches
      cycle(1, 0, 0, 0, 32'h0);
      normal(3);
      after_edge();
      check("run_pc", pc, 32'h0000_000C);
      check("run_inst", id_inst, 32'h0109_5020);
      check("run_fetch_cnt", fetch_cnt, 32'd3);

      // Two-cycle stall at pc=8
      cycle(1, 0, 0, 0, 32'h0);
      normal(2);
      cycle(0, 1, 0, 0, 32'h0);
      cycle(0, 1, 0, 0, 32'h0);
      after_edge();
      check("stall_pc", pc, 32'h0000_0008);
      check("stall_fetch_cnt", fetch_cnt, 32'd2);
      normal(2);

      // Taken branch with a valid IF/ID entry
      cycle(0, 0, 0, 1, 32'h0000_0040);
      after_edge();
      check("br_pc", pc, 32'h0000_0040);
      check("br_flush_cnt", flush_cnt, 32'd1);
      normal(1);

      // Jump decoded from IF/ID = {0x0800_0010, pc+4 = 8}
      mem[32'h4] = 32'h0800_0010;
      mem_gen++;
      cycle(1, 0, 0, 0, 32'h0);
      normal(2);
      cycle(0, 0, 1, 0, 32'h0);
      after_edge();
      check("jmp_pc", pc, 32'h0000_0040);
      check("jmp_flush_cnt", flush_cnt, 32'd0);
      normal(1);

      // Same jump while stalled holds the PC
      cycle(1, 0, 0, 0, 32'h0);
      normal(2);
      cycle(0, 1, 1, 0, 32'h0);
      after_edge();
      check("jmp_stall_pc", pc, 32'h0000_0008);

      // Branch beats jump and stall together
      cycle(0, 1, 1, 1, 32'h0000_0100);
      after_edge();
      check("br_jmp_pc", pc, 32'h0000_0100);
      check("br_jmp_flush_cnt", flush_cnt, 32'd1);
      normal(2);

      // Reset beats a taken branch
      cycle(1, 0, 0, 1, 32'h0000_0200);
      after_edge();
      check("reset_pc", pc, RESET_PC_DEFAULT);

      // PC wrap at the top of the address space
      cycle(0, 0, 0, 1, 32'hFFFF_FFFC);
      normal(1);
      after_edge();
      check("wrap_pc", pc, 32'h0000_0000);
      check("wrap_pp4", id_pc_plus4, 32'h0000_0000);
      normal(2);

      // Random traffic, including jumps from empty slots
      for (int i = 0; i < 600; i++) begin
         r = ($urandom_range(0, 99) < 2);
         b = ($urandom_range(0, 99) < 10);
         j = ($urandom_range(0, 99) < 25);
         s = ($urandom_range(0, 99) < 25);
         t = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         cycle(r, s, j, b, t);
      end

      guard = 0;
      while (sb.size() != 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core, directly upstream of decode.
- Owns the PC register, drives the instruction-memory address, and latches fetched instruction and PC+4 into the IF/ID pipeline register.
- Applies stall, branch redirect (from EX) and jump redirect (computed here from the IF/ID instruction when decode asserts jmp).
- Keeps free-running fetch/flush event counters for performance debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0).

Ports:
- ctrl_bus  interface (ctrl_bus_if.central)  -  carries clk and reset. One clock; reset is synchronous and active-high.
- imem_bus  interface (mem_bus_if.central)  -  instruction memory. addr is driven from pc; data is read combinationally in the same cycle.
- stall  input  1  hold PC and IF/ID (load-use hazard from hazard unit).
- jmp  input  1  decode has identified a j instruction in IF/ID.
- br_taken  input  1  EX resolved a taken beq.
- br_target  input  32  branch target from EX (pc_plus4 + offset<<2).
- pc  output  32  current fetch PC.
- id_inst  output  32  IF/ID instruction.
- id_pc_plus4  output  32  IF/ID PC+4.
- id_valid  output  1  IF/ID holds a real instruction (0 means bubble).
- fetch_cnt  output  32  valid instructions latched into IF/ID.
- flush_cnt  output  32  valid IF/ID entries discarded by redirect.

Behaviour:
- Reset values (synchronous, on the edge with reset=1): pc=RESET_PC, id_inst=NOP, id_pc_plus4=0, id_valid=0, fetch_cnt=0, flush_cnt=0. Reset overrides all other inputs.
- imem_bus.addr = pc, combinational. The instruction is available in the same cycle; fetch has zero cycles of latency into IF/ID (latched at the next edge).
- pc_plus4 = pc + 4, 32-bit modular (0xFFFF_FFFC wraps to 0).
- jmp_target = {id_pc_plus4[31:28], id_inst[25:0], 2'b00}.
- Per-edge priority (highest first):
  1. br_taken: pc <= br_target. IF/ID <= bubble (NOP, valid=0, pc_plus4=0). If the previous id_valid=1, flush_cnt++. stall is ignored.
  2. jmp && !stall: pc <= jmp_target. IF/ID <= bubble. flush_cnt is not incremented (the jump is not discarded; the just-fetched slot is never latched).
  3. stall: pc, IF/ID and counters hold.
  4. normal: pc <= pc_plus4. IF/ID <= {imem data, pc_plus4, valid=1}. fetch_cnt++.
- jmp with id_valid=0 is a protocol error: the block ignores jmp and treats the cycle as normal (or stall).
- br_taken together with jmp: the branch wins (older instruction); the jump in IF/ID is squashed with the bubble.
- The first fetch after reset deasserts occurs at PC=RESET_PC; id_valid rises one cycle later.
- Counters wrap modulo 2^32 and have no saturation.
- No state machine beyond the pipeline-register valid bit; all decisions are single-cycle.

Decomposition:
- Shared package cpu_pkg: NOP constant, RESET_PC default, and typedef if_id_t (struct: inst, pc_plus4, valid).
- Reuse the existing ff for the PC register and the existing mux2 for the redirect select.
- One natural sub-module: if_id_reg (enable + synchronous clear pipeline register of if_id_t).

Test Plan:
- Reset, then 3 free-run cycles with imem returning 0x2008_0005, 0x2009_0003, 0x0109_5020 → pc steps 0, 4, 8, 0xC; id_inst follows one cycle behind; id_pc_plus4 = 4, 8, 0xC; fetch_cnt=3.
- stall held 2 cycles at pc=8 → pc, id_inst and fetch_cnt unchanged for 2 edges; fetch resumes at 8 and then 0xC.
- br_taken=1, br_target=0x40 while id_valid=1 → next pc=0x40, id_valid=0, id_inst=0, flush_cnt=1; the following edge latches the instruction from 0x40.
- id_inst=0x0800_0010, id_pc_plus4=0x0000_0008, jmp=1 → pc=0x0000_0040, IF/ID bubble, flush_cnt unchanged. Repeat with stall=1 → pc holds.
- br_taken=1 (target 0x100) with jmp=1 and stall=1 in the same cycle → pc=0x100, bubble, flush_cnt++.
- Reset asserted mid-run with br_taken=1 → pc=RESET_PC, all outputs at reset values; pc=0xFFFF_FFFC in normal flow → wraps to 0.
